// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
// One shift per clock; a conversion takes WIDTH shifts after the accepting
// edge, then a single DONE cycle in which a new request may be accepted.
//
// Handshake: a request is accepted on any rising edge where start=1 and the
// FSM is in IDLE or DONE; bin is captured on that same edge. While busy=1
// start is ignored and the request is dropped. done=1 for exactly one cycle,
// and bcd/blank change only on the edge that raises done.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic [1:0]            dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  // Blank pattern for a display showing a single "0".
  localparam logic [DIGITS-1:0] BLANK_ZERO = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     binreg;
  logic [4*DIGITS-1:0]  scratch;
  logic [CW-1:0]        cnt;
  logic [4*DIGITS-1:0]  adj;
  logic [4*DIGITS-1:0]  shifted;
  logic [DIGITS-1:0]    blank_calc;
  logic                 accept;
  logic                 last_shift;

  assign accept     = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_shift = (cnt == LAST_CNT);
  assign dbg_state  = state;

  // Add-3 correction on every scratch digit, then shift in the binreg MSB.
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      else
        adj[4*i +: 4] = scratch[4*i +: 4];
    end
    shifted = (adj << 1) | {{(4*DIGITS-1){1'b0}}, binreg[WIDTH-1]};
  end

  // Leading-zero mask of the post-shift result; digit 0 is never blanked.
  always_comb begin
    logic all_zero;
    all_zero   = 1'b1;
    blank_calc = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero      = all_zero && (shifted[4*i +: 4] == 4'd0);
      blank_calc[i] = all_zero;
    end
    blank_calc[0] = 1'b0;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; DONE accepts a new request exactly like IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = start ? S_SHIFT : S_IDLE;
      S_SHIFT: state_nxt = last_shift ? S_DONE : S_SHIFT;
      S_DONE:  state_nxt = start ? S_SHIFT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state register only.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture on accept, shift while busy, load results on the last shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      binreg  <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd     <= '0;
      blank   <= BLANK_ZERO;
    end else if (accept) begin
      binreg  <= bin;
      scratch <= '0;
      cnt     <= '0;
    end else if (state == S_SHIFT) begin
      binreg  <= {binreg[WIDTH-2:0], 1'b0};
      scratch <= shifted;
      cnt     <= cnt + 1'b1;
      if (last_shift) begin
        bcd   <= shifted;
        blank <= blank_calc;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed scenarios on the 16-bit/5-digit default
// and an exhaustive back-to-back sweep on an 8-bit/3-digit instance.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start16, start8;
  logic [15:0] bin16;
  logic [7:0]  bin8;
  logic        busy16, done16, busy8, done8;
  logic [19:0] bcd16;
  logic [11:0] bcd8;
  logic [4:0]  blank16;
  logic [2:0]  blank8;
  logic [1:0]  st16, st8;

  int vectors = 0;
  int fails   = 0;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .bin(bin16),
    .busy(busy16), .done(done16), .bcd(bcd16), .blank(blank16),
    .dbg_state(st16)
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .bin(bin8),
    .busy(busy8), .done(done8), .bcd(bcd8), .blank(blank8),
    .dbg_state(st8)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Reference model: decimal digits by division, blank bit i set when v < 10^i.
  function automatic logic [31:0] ref_bcd(input int v, input int nd);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < nd; i++) begin
      r = r | (32'(x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_blank(input int v, input int nd);
    logic [31:0] r;
    int p;
    r = '0;
    p = 10;
    for (int i = 1; i < nd; i++) begin
      if (v < p) r[i] = 1'b1;
      p = p * 10;
    end
    return r;
  endfunction

  // Scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: advance one rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: one 16-bit conversion from IDLE; reports edges to done and busy cycles
  task automatic convert16(input int v, output int lat, output int busy_cycles);
    bin16   = 16'(v);
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    lat = 0;
    busy_cycles = 0;
    while (!done16 && lat < 100) begin
      if (busy16) busy_cycles++;
      if (busy16 && done16) chk("busy_done_overlap", 1, 0);
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bc, n, ndone;
    logic [31:0] got;
    reset   = 1'b1;
    start16 = 1'b0;
    start8  = 1'b0;
    bin16   = '0;
    bin8    = '0;
    #12;
    chk("rst_busy", 32'(busy16), 0);
    chk("rst_done", 32'(done16), 0);
    chk("rst_bcd", 32'(bcd16), 0);
    chk("rst_blank", 32'(blank16), 32'b11110);
    chk("rst_bcd8", 32'(bcd8), 0);
    chk("rst_blank8", 32'(blank8), 32'b110);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Zero conversion: timing and leading-zero mask
    convert16(0, lat, bc);
    chk("zero_latency", 32'(lat), 16);
    chk("zero_busy_cycles", 32'(bc), 16);
    chk("zero_done", 32'(done16), 1);
    chk("zero_bcd", 32'(bcd16), ref_bcd(0, 5));
    chk("zero_blank", 32'(blank16), ref_blank(0, 5));
    tick();
    chk("zero_done_pulse", 32'(done16), 0);
    chk("zero_idle_busy", 32'(busy16), 0);

    convert16(65535, lat, bc);
    chk("max_latency", 32'(lat), 16);
    chk("max_bcd", 32'(bcd16), 32'h65535);
    chk("max_blank", 32'(blank16), 32'b00000);
    tick();

    convert16(1234, lat, bc);
    chk("1234_bcd", 32'(bcd16), 32'h01234);
    chk("1234_blank", 32'(blank16), 32'b10000);
    tick();

    // Random values
    for (int k = 0; k < 8; k++) begin
      int v;
      v = int'($urandom_range(0, 65535));
      convert16(v, lat, bc);
      chk("rand_latency", 32'(lat), 16);
      chk("rand_bcd", 32'(bcd16), ref_bcd(v, 5));
      chk("rand_blank", 32'(blank16), ref_blank(v, 5));
      tick();
    end

    // Second convert of 1234 so the held value below is known
    convert16(1234, lat, bc);
    tick();

    // start during SHIFT is ignored
    bin16   = 16'd100;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    repeat (3) tick();
    chk("hold_bcd", 32'(bcd16), 32'h01234);
    bin16   = 16'd999;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    bin16   = '0;
    chk("ignore_busy", 32'(busy16), 1);
    chk("hold_bcd2", 32'(bcd16), 32'h01234);
    ndone = 0;
    got = '0;
    for (int k = 0; k < 40; k++) begin
      if (done16) begin
        ndone++;
        got = 32'(bcd16);
      end
      tick();
    end
    chk("ignore_done_count", 32'(ndone), 1);
    chk("ignore_bcd", got, 32'h00100);

    // Back-to-back accept in DONE
    convert16(42, lat, bc);
    chk("b2b_first_bcd", 32'(bcd16), 32'h00042);
    bin16   = 16'd9000;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    chk("b2b_no_idle", 32'(busy16), 1);
    n = 1;
    while (!done16 && n < 100) begin
      tick();
      n++;
    end
    chk("b2b_spacing", 32'(n), 17);
    chk("b2b_bcd", 32'(bcd16), 32'h09000);
    chk("b2b_blank", 32'(blank16), 32'b10000);
    tick();

    // Asynchronous reset mid-conversion
    bin16   = 16'd4321;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    repeat (7) tick();
    chk("pre_reset_busy", 32'(busy16), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy16), 0);
    chk("async_rst_done", 32'(done16), 0);
    chk("async_rst_bcd", 32'(bcd16), 0);
    chk("async_rst_blank", 32'(blank16), 32'b11110);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done16) ndone++;
    end
    chk("post_rst_no_done", 32'(ndone), 0);
    convert16(7, lat, bc);
    chk("post_rst_latency", 32'(lat), 16);
    chk("post_rst_bcd", 32'(bcd16), 32'h00007);
    chk("post_rst_blank", 32'(blank16), 32'b11110);
    tick();

    // 8-bit exhaustive sweep, start held high so every accept is from DONE
    bin8   = 8'd0;
    start8 = 1'b1;
    tick();
    for (int v = 0; v < 256; v++) begin
      n = 0;
      while (!done8 && n < 50) begin
        tick();
        n++;
      end
      chk("w8_spacing", 32'(n), 8);
      chk("w8_busy_at_done", 32'(busy8), 0);
      chk("w8_bcd", 32'(bcd8), ref_bcd(v, 3));
      chk("w8_blank", 32'(blank8), ref_blank(v, 3));
      if (v == 255) begin
        chk("w8_255", 32'(bcd8), 32'h255);
        start8 = 1'b0;
      end
      if (v == 9) begin
        chk("w8_9_bcd", 32'(bcd8), 32'h009);
        chk("w8_9_blank", 32'(blank8), 32'b110);
      end
      bin8 = 8'(v + 1);
      tick();
    end
    chk("w8_final_idle", 32'(done8), 0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential double-dabble converter that turns an unsigned binary value into packed BCD digits for the seven-segment display path. It sits directly upstream of the per-digit BCD-to-segment decoders: each 4-bit slice of `bcd` drives one decoder, and `blank` lets the display driver suppress leading zeros. It uses one shift per clock, so area stays small at the cost of WIDTH+1 cycles per conversion.

## Interface
- `WIDTH`, 16, bit width of the binary input (≥ 4).
- `DIGITS`, 5, number of BCD digits output. Must satisfy 10^DIGITS − 1 ≥ 2^WIDTH − 1. The design does not detect overflow.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  request conversion of `bin`. Sampled only in IDLE or DONE.
- `bin`  input  WIDTH  unsigned binary operand, captured on the accepting edge.
- `busy`  output  1  high while the state is SHIFT.
- `done`  output  1  one-cycle pulse; `bcd`/`blank` are updated and valid.
- `bcd`  output  4*DIGITS  packed BCD result; digit i at bits [4i+3:4i], digit 0 is the least significant.
- `blank`  output  DIGITS  bit i = 1 when digit i and all higher digits are zero. Bit 0 is always 0.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: when `start`=1, capture `bin` into the shift register, clear the BCD scratch register and the shift counter, then go to SHIFT.
  - SHIFT: each cycle, for every scratch digit ≥ 5 add 3 (4-bit, no carry out), then shift {scratch, binreg} left by 1. The MSB of binreg enters bit 0 of digit 0. Increment the counter. On the WIDTH-th shift, load `bcd` with the post-shift scratch value, load `blank` from the same value, and go to DONE.
  - DONE: `done`=1. If `start`=1, behave exactly as IDLE accepting a request (back-to-back). Otherwise go to IDLE.
- `start` is ignored in SHIFT. No queueing; the request is lost.
- `bcd`/`blank` are registered and hold the previous result for the whole conversion. They change only on the completing edge.
- The counter is ceil(log2(WIDTH+1)) bits wide and has no wrap-around within a conversion.
- Add-3 correction is applied to all DIGITS digits every shift. This is harmless for digits that are still zero.
- Reset (any time, including mid-SHIFT) forces immediately:
  - state IDLE;
  - `busy`=0, `done`=0;
  - `bcd`=0;
  - `blank`= all ones except bit 0 (that is, a display showing "0").
  - The aborted conversion produces no `done`.

## Timing
- `start` accepted at edge N puts the FSM in SHIFT from N through N+WIDTH−1.
- `busy`=1 in the cycles after edges N .. N+WIDTH−1, for WIDTH cycles in total.
- The final shift and the output load happen at edge N+WIDTH.
- `done`=1 for exactly the cycle after edge N+WIDTH. `bcd` is valid from that edge onward.
- Latency: WIDTH+1 clock edges from the accepting edge to the deassertion of `done`.
- Minimum start-to-start spacing is WIDTH+1 cycles, using the DONE-state accept.
- `busy` and `done` are never high in the same cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then `bin`=0 with `start` pulse → `busy` high 16 cycles, `done` at cycle 17, `bcd`=0x00000, `blank`=5'b11110.
- `bin`=65535 → `bcd`=0x65535, `blank`=5'b00000. Repeat with 1234 → `bcd`=0x01234, `blank`=5'b10000.
- Start 100, then pulse `start` with `bin`=999 mid-SHIFT → the request is ignored, the result is 0x00100, and only one `done` occurs. `bcd` holds the prior value until completion.
- Start 42, then hold `start` high with `bin`=9000 during the `done` cycle → a second conversion is accepted with no IDLE cycle, and the second `done` comes exactly 17 cycles after the first with `bcd`=0x09000.
- Assert `reset` at shift 8 of a conversion of 4321 → outputs immediately go to their reset values. After release there is no `done` until a new `start`, and a fresh conversion of 7 gives 0x00007 with `blank`=5'b11110.
- Parameter variant WIDTH=8, DIGITS=3: exhaustive sweep of 0..255 against a reference model. Check `done` spacing of 9 cycles, `bcd` for 255 = 0x255, and `bcd` for 9 = 0x009 with `blank`=3'b110.
